// File: rtl/l1_ahb_mtx_in_stg_if.sv
// Bus bundle for one L1 AHB matrix input stage: master-side AHB signals plus
// the decoder-side select/address/control and handshake returns.
interface l1_ahb_mtx_in_stg_if #(
  parameter int ADDR_W = 32
);
  logic              HSELS;
  logic [ADDR_W-1:0] HADDRS;
  logic [1:0]        HTRANSS;
  logic              HWRITES;
  logic [2:0]        HSIZES;
  logic [2:0]        HBURSTS;
  logic [3:0]        HPROTS;
  logic              HMASTLOCKS;
  logic              HREADYS;
  logic [31:0]       HAUSERS;
  logic              HREADYOUTS;
  logic [1:0]        HRESPS;

  logic              sel_op;
  logic [ADDR_W-1:0] addr_op;
  logic [1:0]        trans_op;
  logic              write_op;
  logic [2:0]        size_op;
  logic [2:0]        burst_op;
  logic [3:0]        prot_op;
  logic              mastlock_op;
  logic [31:0]       auser_op;
  logic              ready_op;
  logic              active_op;
  logic              readyout_op;
  logic [1:0]        resp_op;

  modport master (
    output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
           HMASTLOCKS, HREADYS, HAUSERS,
    input  HREADYOUTS, HRESPS
  );

  modport slave (
    input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
           HMASTLOCKS, HREADYS, HAUSERS,
    output HREADYOUTS, HRESPS,
    output sel_op, addr_op, trans_op, write_op, size_op, burst_op, prot_op,
           mastlock_op, auser_op, ready_op,
    input  active_op, readyout_op, resp_op
  );

  modport decoder (
    input  sel_op, addr_op, trans_op, write_op, size_op, burst_op, prot_op,
           mastlock_op, auser_op, ready_op,
    output active_op, readyout_op, resp_op
  );
endinterface

// File: rtl/l1_ahb_mtx_in_stg.sv
// L1 AHB matrix input stage: one-deep holding register that parks an address
// phase the target cannot take yet. Optional macro: L1AHBMTX_IN_STG_AUSER_EN.
module l1_ahb_mtx_in_stg #(
  parameter int ADDR_W = 32
) (
  input logic                HCLK,
  input logic                HRESETn,
  l1_ahb_mtx_in_stg_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_PEND = 2'b10
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [1:0]        trans;
    logic              write;
    logic [2:0]        size;
    logic [2:0]        burst;
    logic [3:0]        prot;
    logic              mastlock;
  } hold_t;

  state_t state_q;
  hold_t  hold_q;
  hold_t  hold_d;
  logic   pend_s;
  logic   dphase_s;
  logic   valid_in_s;
  logic   capture_s;

`ifdef L1AHBMTX_IN_STG_AUSER_EN
  logic [31:0] auser_q;
  logic [31:0] auser_d;
`endif

  assign pend_s     = (state_q == ST_PEND);
  assign dphase_s   = (state_q == ST_DATA);
  assign valid_in_s = bus.HSELS & bus.HTRANSS[1] & bus.HREADYS;
  assign capture_s  = ~pend_s & valid_in_s & ~bus.active_op;

  // Holding register next value; SEQ is normalised to NONSEQ on capture.
  always_comb begin
    hold_d = hold_q;
`ifdef L1AHBMTX_IN_STG_AUSER_EN
    auser_d = auser_q;
`endif
    if (capture_s) begin
      hold_d.addr     = bus.HADDRS;
      hold_d.trans    = {bus.HTRANSS[1], 1'b0};
      hold_d.write    = bus.HWRITES;
      hold_d.size     = bus.HSIZES;
      hold_d.burst    = bus.HBURSTS;
      hold_d.prot     = bus.HPROTS;
      hold_d.mastlock = bus.HMASTLOCKS;
`ifdef L1AHBMTX_IN_STG_AUSER_EN
      auser_d         = bus.HAUSERS;
`endif
    end else begin
      hold_d = hold_q;
    end
  end

  // Address-phase mux towards the decoder and output stages.
  always_comb begin
    if (pend_s) begin
      bus.sel_op      = 1'b1;
      bus.addr_op     = hold_q.addr;
      bus.trans_op    = hold_q.trans;
      bus.write_op    = hold_q.write;
      bus.size_op     = hold_q.size;
      bus.burst_op    = hold_q.burst;
      bus.prot_op     = hold_q.prot;
      bus.mastlock_op = hold_q.mastlock;
      bus.ready_op    = bus.readyout_op;
    end else begin
      bus.sel_op      = bus.HSELS;
      bus.addr_op     = bus.HADDRS;
      bus.trans_op    = bus.HTRANSS;
      bus.write_op    = bus.HWRITES;
      bus.size_op     = bus.HSIZES;
      bus.burst_op    = bus.HBURSTS;
      bus.prot_op     = bus.HPROTS;
      bus.mastlock_op = bus.HMASTLOCKS;
      bus.ready_op    = bus.HREADYS;
    end
  end

`ifdef L1AHBMTX_IN_STG_AUSER_EN
  assign bus.auser_op = pend_s ? auser_q : bus.HAUSERS;
`else
  assign bus.auser_op = 32'h0000_0000;
`endif

  // Master-facing response; only state and decoder returns feed HREADYOUTS.
  always_comb begin
    if (pend_s) begin
      bus.HREADYOUTS = 1'b0;
      bus.HRESPS     = 2'b00;
    end else if (dphase_s) begin
      bus.HREADYOUTS = bus.readyout_op;
      bus.HRESPS     = bus.resp_op;
    end else begin
      bus.HREADYOUTS = 1'b1;
      bus.HRESPS     = 2'b00;
    end
  end

  // Stage state machine and holding register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
`ifdef L1AHBMTX_IN_STG_AUSER_EN
      auser_q <= 32'h0000_0000;
`endif
    end else begin
      hold_q <= hold_d;
`ifdef L1AHBMTX_IN_STG_AUSER_EN
      auser_q <= auser_d;
`endif
      case (state_q)
        ST_PEND: begin
          if (bus.active_op & bus.readyout_op) begin
            state_q <= ST_DATA;
          end else begin
            state_q <= ST_PEND;
          end
        end
        ST_IDLE, ST_DATA: begin
          if (valid_in_s & ~bus.active_op) begin
            state_q <= ST_PEND;
          end else if (valid_in_s) begin
            state_q <= ST_DATA;
          end else if (bus.HREADYS) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= state_q;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l1_ahb_mtx_in_stg.sv
// Scoreboard bench for l1_ahb_mtx_in_stg: expected address phases are queued
// when driven and compared when the decoder accepts them.
module tb_l1_ahb_mtx_in_stg;

`ifdef L1AHBMTX_IN_STG_AUSER_EN
  localparam bit AUSER_ON = 1'b1;
`else
  localparam bit AUSER_ON = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic        ml;
    logic [31:0] au;
  } exp_t;

  logic HCLK;
  logic HRESETn;
  int   total;
  int   bad;
  logic m_pend;
  exp_t sb[$];

  l1_ahb_mtx_in_stg_if #(.ADDR_W(32)) bus_if ();

  l1_ahb_mtx_in_stg #(.ADDR_W(32)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus_if)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Bench-side expectation of whether a transfer is parked in the stage.
  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) m_pend <= 1'b0;
    else if (m_pend) begin
      if (bus_if.active_op && bus_if.readyout_op) m_pend <= 1'b0;
    end else if (bus_if.HSELS && bus_if.HTRANSS[1] && bus_if.HREADYS && !bus_if.active_op)
      m_pend <= 1'b1;
  end

  task automatic drive(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                       input logic wr, input logic [31:0] au, input logic hr,
                       input logic act, input logic rdy, input logic [1:0] rsp);
    exp_t e;
    @(posedge HCLK);
    #1;
    bus_if.HSELS       = sel;
    bus_if.HTRANSS     = tr;
    bus_if.HADDRS      = a;
    bus_if.HWRITES     = wr;
    bus_if.HSIZES      = {1'b0, wr, 1'b1};
    bus_if.HBURSTS     = {1'b0, tr} + 3'd1;
    bus_if.HPROTS      = a[31:28];
    bus_if.HMASTLOCKS  = wr;
    bus_if.HAUSERS     = au;
    bus_if.HREADYS     = hr;
    bus_if.active_op   = act;
    bus_if.readyout_op = rdy;
    bus_if.resp_op     = rsp;
    if (sel && tr[1] && hr && !m_pend) begin
      e.addr  = a;
      e.trans = act ? tr : 2'b10;
      e.wr    = wr;
      e.size  = {1'b0, wr, 1'b1};
      e.burst = {1'b0, tr} + 3'd1;
      e.prot  = a[31:28];
      e.ml    = wr;
      e.au    = AUSER_ON ? au : 32'h0000_0000;
      sb.push_back(e);
    end
    @(negedge HCLK);
  endtask

  // Compare whatever the decoder accepts against the oldest queued expectation.
  always @(negedge HCLK) begin
    exp_t e;
    if (HRESETn && bus_if.sel_op && bus_if.trans_op[1] && bus_if.active_op && bus_if.ready_op) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("acc_addr",  {32'd0, bus_if.addr_op},     {32'd0, e.addr});
        chk("acc_trans", {62'd0, bus_if.trans_op},    {62'd0, e.trans});
        chk("acc_write", {63'd0, bus_if.write_op},    {63'd0, e.wr});
        chk("acc_size",  {61'd0, bus_if.size_op},     {61'd0, e.size});
        chk("acc_burst", {61'd0, bus_if.burst_op},    {61'd0, e.burst});
        chk("acc_prot",  {60'd0, bus_if.prot_op},     {60'd0, e.prot});
        chk("acc_lock",  {63'd0, bus_if.mastlock_op}, {63'd0, e.ml});
        chk("acc_auser", {32'd0, bus_if.auser_op},    {32'd0, e.au});
      end
    end
  end

  initial begin
    logic [31:0] au_exp;
    total = 0;
    bad   = 0;
    au_exp = AUSER_ON ? 32'hA5A5_0001 : 32'h0000_0000;
    HRESETn = 1'b0;
    bus_if.HSELS = 1'b1;       bus_if.HTRANSS = 2'b00;  bus_if.HADDRS = 32'h1234_5678;
    bus_if.HWRITES = 1'b0;     bus_if.HSIZES = 3'd0;    bus_if.HBURSTS = 3'd0;
    bus_if.HPROTS = 4'd0;      bus_if.HMASTLOCKS = 1'b0; bus_if.HREADYS = 1'b1;
    bus_if.HAUSERS = 32'd0;    bus_if.active_op = 1'b0; bus_if.readyout_op = 1'b1;
    bus_if.resp_op = 2'b01;
    #2;
    chk("rst_hreadyout", {63'd0, bus_if.HREADYOUTS}, 64'd1);
    chk("rst_hresp",     {62'd0, bus_if.HRESPS},     64'd0);
    chk("rst_addr_thru", {32'd0, bus_if.addr_op},    64'h1234_5678);
    chk("rst_sel_thru",  {63'd0, bus_if.sel_op},     64'd1);
    #10 HRESETn = 1'b1;

    // Direct pass, then a wait state and completion.
    drive(1'b1, 2'b10, 32'h1000_0040, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 2'b00);
    chk("dir_sel",  {63'd0, bus_if.sel_op},  64'd1);
    chk("dir_addr", {32'd0, bus_if.addr_op}, 64'h1000_0040);
    chk("dir_rdy_op", {63'd0, bus_if.ready_op}, 64'd1);
    drive(1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 2'b00);
    chk("dir_dp_wait", {63'd0, bus_if.HREADYOUTS}, 64'd0);
    drive(1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 2'b00);
    chk("dir_dp_done", {63'd0, bus_if.HREADYOUTS}, 64'd1);

    // Capture and replay with a 3-cycle grant delay; master stalls meanwhile.
    drive(1'b1, 2'b10, 32'h3000_0008, 1'b1, 32'hA5A5_0001, 1'b1, 1'b0, 1'b1, 2'b00);
    chk("cap_addr_thru", {32'd0, bus_if.addr_op}, 64'h3000_0008);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b10, 32'h5555_0000, 1'b0, 32'hFFFF_0000, 1'b0,
            (i == 2), (i != 0), 2'b00);
      chk("pend_hreadyout", {63'd0, bus_if.HREADYOUTS}, 64'd0);
      chk("pend_addr",  {32'd0, bus_if.addr_op},  64'h3000_0008);
      chk("pend_trans", {62'd0, bus_if.trans_op}, 64'd2);
      chk("pend_auser", {32'd0, bus_if.auser_op}, {32'd0, au_exp});
      chk("pend_rdy_op", {63'd0, bus_if.ready_op}, {63'd0, (i != 0)});
    end
    drive(1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 2'b00);
    chk("rep_dphase", {63'd0, bus_if.HREADYOUTS}, 64'd0);
    drive(1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 2'b00);
    chk("rep_done", {63'd0, bus_if.HREADYOUTS}, 64'd1);

    // Held SEQ is replayed as NONSEQ.
    drive(1'b1, 2'b11, 32'h0000_0004, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 2'b00);
    drive(1'b1, 2'b11, 32'h0000_0008, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 2'b00);
    chk("seq_trans", {62'd0, bus_if.trans_op}, 64'd2);
    chk("seq_addr",  {32'd0, bus_if.addr_op},  64'h0000_0004);
    drive(1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 2'b00);
    chk("seq_done", {63'd0, bus_if.HREADYOUTS}, 64'd1);

    // Two-cycle ERROR pass-through, then response masked outside data phase.
    drive(1'b1, 2'b10, 32'h2000_0000, 1'b1, 32'h0, 1'b1, 1'b1, 1'b1, 2'b00);
    drive(1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 2'b01);
    chk("err1_resp", {62'd0, bus_if.HRESPS},     64'd1);
    chk("err1_rdy",  {63'd0, bus_if.HREADYOUTS}, 64'd0);
    drive(1'b1, 2'b00, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 2'b01);
    chk("err2_resp", {62'd0, bus_if.HRESPS},     64'd1);
    chk("err2_rdy",  {63'd0, bus_if.HREADYOUTS}, 64'd1);
    drive(1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 2'b01);
    chk("idle_resp_mask", {62'd0, bus_if.HRESPS}, 64'd0);

    // BUSY with no grant is never captured.
    drive(1'b1, 2'b01, 32'h4000_0000, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 2'b00);
    drive(1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 2'b00);
    chk("busy_nocap_rdy", {63'd0, bus_if.HREADYOUTS}, 64'd1);
    chk("busy_nocap_sel", {63'd0, bus_if.sel_op},     64'd0);

    // Reset while holding discards the parked transfer asynchronously.
    drive(1'b1, 2'b10, 32'h6000_0000, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 2'b00);
    drive(1'b1, 2'b10, 32'h7000_0000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2'b00);
    chk("rh_pend_rdy",  {63'd0, bus_if.HREADYOUTS}, 64'd0);
    chk("rh_pend_addr", {32'd0, bus_if.addr_op},    64'h6000_0000);
    #2;
    bus_if.HSELS = 1'b0;
    HRESETn = 1'b0;
    #1;
    chk("rh_hreadyout", {63'd0, bus_if.HREADYOUTS}, 64'd1);
    chk("rh_hresp",     {62'd0, bus_if.HRESPS},     64'd0);
    chk("rh_sel",       {63'd0, bus_if.sel_op},     64'd0);
    sb.delete();
    #1 HRESETn = 1'b1;

    // Recovery: a fresh direct transfer after reset.
    drive(1'b1, 2'b10, 32'h1000_0080, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 2'b00);
    chk("post_addr", {32'd0, bus_if.addr_op}, 64'h1000_0080);
    drive(1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 2'b00);
    chk("post_rdy", {63'd0, bus_if.HREADYOUTS}, 64'd1);
    chk("sb_left", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
